packet_rr_arbiter: RTL and testbench

- Round-robin, packet-locked arbiter sharing one downstream output among DIMENSION upstream requesters.
- Produces the one-hot PacketEnable_dw_o grant vector that drives the priority data mux (Mux) selecting Data_up_i onto the shared output.
- Handles valid/ready handshaking and holds each grant for a whole packet, until its tail flit transfers.
- Flags packets longer than MAX_FLITS.

---
 rtl/packet_rr_arbiter.sv | 140 ++++++++++++++
 tb/tb_packet_rr_arbiter.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/packet_rr_arbiter.sv
// Round-robin, packet-locked arbiter: grants one upstream requester the shared
// downstream port for a whole packet and flags packets longer than MAX_FLITS.
module packet_rr_arbiter #(
    parameter int DIMENSION = 4,
    parameter int MAX_FLITS = 16
) (
    input  logic                 Clk,
    input  logic                 Rst_n,
    input  logic [DIMENSION-1:0] Valid_up_i,
    input  logic [DIMENSION-1:0] Tail_up_i,
    output logic [DIMENSION-1:0] Ready_up_o,
    output logic [DIMENSION-1:0] PacketEnable_dw_o,
    output logic                 Valid_dw_o,
    output logic                 Tail_dw_o,
    input  logic                 Ready_dw_i,
    output logic                 PktLenErr_o,
    input  logic                 PktLenErrClr_i
);

    localparam int PW = (DIMENSION > 1) ? $clog2(DIMENSION) : 1;
    localparam int CW = $clog2(MAX_FLITS + 2);

    typedef logic [PW-1:0] ptr_t;
    typedef logic [CW-1:0] cnt_t;
    typedef enum logic [0:0] {
        ST_IDLE   = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    localparam cnt_t CNT_MAX = cnt_t'(MAX_FLITS);
    localparam cnt_t CNT_SAT = cnt_t'(MAX_FLITS + 1);

    state_t               r_state;
    logic [DIMENSION-1:0] r_grant;
    ptr_t                 r_gidx;
    ptr_t                 r_ptr;
    cnt_t                 r_cnt;
    logic                 r_err;

    logic                 w_valid_dw;
    logic                 w_tail_dw;
    logic                 w_xfer;
    logic                 w_err_set;
    logic                 w_pick_any;
    ptr_t                 w_pick_idx;
    logic [DIMENSION-1:0] w_pick_oh;

    // Modulo-DIMENSION increment, valid for non-power-of-two DIMENSION too.
    function automatic ptr_t wrap_inc(input ptr_t idx);
        ptr_t nxt;
        if (idx == ptr_t'(DIMENSION - 1)) begin
            nxt = '0;
        end else begin
            nxt = idx + ptr_t'(1);
        end
        return nxt;
    endfunction

    assign w_valid_dw = |(r_grant & Valid_up_i);
    assign w_tail_dw  = |(r_grant & Valid_up_i & Tail_up_i);
    assign w_xfer     = w_valid_dw & Ready_dw_i;
    assign w_err_set  = (r_state == ST_LOCKED) & w_xfer & (r_cnt == CNT_MAX);

    assign Ready_up_o        = r_grant & {DIMENSION{Ready_dw_i}};
    assign PacketEnable_dw_o = r_grant;
    assign Valid_dw_o        = w_valid_dw;
    assign Tail_dw_o         = w_tail_dw;
    assign PktLenErr_o       = r_err;

    // Round-robin scan: first valid requester starting at the pointer, with wrap.
    always_comb begin : arb_scan
        ptr_t v_scan;
        w_pick_any = 1'b0;
        w_pick_idx = r_ptr;
        v_scan     = r_ptr;
        for (int k = 0; k < DIMENSION; k++) begin
            if (!w_pick_any && Valid_up_i[v_scan]) begin
                w_pick_any = 1'b1;
                w_pick_idx = v_scan;
            end else begin
                w_pick_any = w_pick_any;
            end
            v_scan = wrap_inc(v_scan);
        end
        w_pick_oh = {{(DIMENSION-1){1'b0}}, 1'b1} << w_pick_idx;
    end

    // Arbitration FSM: grant, pointer and per-packet flit counter.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_gidx  <= '0;
            r_ptr   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_cnt <= '0;
                    if (w_pick_any) begin
                        r_grant <= w_pick_oh;
                        r_gidx  <= w_pick_idx;
                        r_state <= ST_LOCKED;
                    end else begin
                        r_grant <= '0;
                    end
                end
                ST_LOCKED: begin
                    if (w_xfer) begin
                        if (r_cnt != CNT_SAT) begin
                            r_cnt <= r_cnt + cnt_t'(1);
                        end
                        if (w_tail_dw) begin
                            r_grant <= '0;
                            r_ptr   <= wrap_inc(r_gidx);
                            r_state <= ST_IDLE;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                    r_cnt   <= '0;
                end
            endcase
        end
    end

    // Sticky length error; a new error beats a simultaneous clear.
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            r_err <= 1'b0;
        end else if (w_err_set) begin
            r_err <= 1'b1;
        end else if (PktLenErrClr_i) begin
            r_err <= 1'b0;
        end
    end

endmodule

// File: tb/tb_packet_rr_arbiter.sv
// Directed, table-driven bench for packet_rr_arbiter (DIMENSION=4, MAX_FLITS=16).
module tb_packet_rr_arbiter;

    logic       Clk;
    logic       Rst_n;
    logic [3:0] Valid_up_i;
    logic [3:0] Tail_up_i;
    logic [3:0] Ready_up_o;
    logic [3:0] PacketEnable_dw_o;
    logic       Valid_dw_o;
    logic       Tail_dw_o;
    logic       Ready_dw_i;
    logic       PktLenErr_o;
    logic       PktLenErrClr_i;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [3:0] valid;
        logic [3:0] tail;
        logic       ready;
        logic [3:0] grant;
        logic [3:0] rdy;
        logic       vdw;
        logic       tdw;
    } vec_t;

    vec_t tv[$];

    packet_rr_arbiter #(.DIMENSION(4), .MAX_FLITS(16)) dut (
        .Clk               (Clk),
        .Rst_n             (Rst_n),
        .Valid_up_i        (Valid_up_i),
        .Tail_up_i         (Tail_up_i),
        .Ready_up_o        (Ready_up_o),
        .PacketEnable_dw_o (PacketEnable_dw_o),
        .Valid_dw_o        (Valid_dw_o),
        .Tail_dw_o         (Tail_dw_o),
        .Ready_dw_i        (Ready_dw_i),
        .PktLenErr_o       (PktLenErr_o),
        .PktLenErrClr_i    (PktLenErrClr_i)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_grant(input logic [3:0] want);
        for (int c = 0; c < 8 && PacketEnable_dw_o !== want; c++) begin
            @(posedge Clk); #1;
        end
        check("grant_wait", {4'b0, PacketEnable_dw_o}, {4'b0, want});
    endtask

    // Sends one n-flit packet from requester idx; optionally pulses clear on the tail flit.
    task automatic send_pkt(input int idx, input int n, input bit clr_last);
        logic [3:0] oh;
        oh = 4'b0001 << idx;
        Valid_up_i = oh;
        Tail_up_i  = 4'b0000;
        Ready_dw_i = 1'b1;
        wait_grant(oh);
        for (int f = 1; f <= n; f++) begin
            Tail_up_i      = (f == n) ? oh : 4'b0000;
            PktLenErrClr_i = clr_last && (f == n);
            @(posedge Clk); #1;
            PktLenErrClr_i = 1'b0;
            check($sformatf("err_n%0d_f%0d", n, f), {7'b0, PktLenErr_o}, {7'b0, (f >= 17)});
        end
        Valid_up_i = 4'b0000;
        Tail_up_i  = 4'b0000;
    endtask

    initial begin
        Rst_n          = 1'b0;
        Valid_up_i     = 4'b1111;
        Tail_up_i      = 4'b0000;
        Ready_dw_i     = 1'b1;
        PktLenErrClr_i = 1'b0;

        // fairness: 2-flit packets from all four requesters
        tv.push_back('{4'b1111, 4'b0000, 1'b1, 4'b0001, 4'b0001, 1'b1, 1'b0});
        tv.push_back('{4'b1111, 4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b1, 1'b1});
        tv.push_back('{4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0});
        tv.push_back('{4'b1111, 4'b0000, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b0});
        tv.push_back('{4'b1111, 4'b0010, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b1});
        tv.push_back('{4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0});
        tv.push_back('{4'b1111, 4'b0000, 1'b1, 4'b0100, 4'b0100, 1'b1, 1'b0});
        tv.push_back('{4'b1111, 4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b1, 1'b1});
        tv.push_back('{4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0});
        tv.push_back('{4'b1111, 4'b0000, 1'b1, 4'b1000, 4'b1000, 1'b1, 1'b0});
        tv.push_back('{4'b1111, 4'b1000, 1'b1, 4'b1000, 4'b1000, 1'b1, 1'b1});
        tv.push_back('{4'b1111, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0});
        tv.push_back('{4'b0001, 4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b1, 1'b1});
        // lock: req1 4-flit packet while req0/req3 request
        tv.push_back('{4'b0010, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0});
        tv.push_back('{4'b0010, 4'b0000, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b0});
        tv.push_back('{4'b1011, 4'b0000, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b0});
        tv.push_back('{4'b1011, 4'b1001, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b0});
        tv.push_back('{4'b1011, 4'b0010, 1'b1, 4'b0010, 4'b0010, 1'b1, 1'b1});
        tv.push_back('{4'b1001, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0});
        tv.push_back('{4'b1001, 4'b1000, 1'b1, 4'b1000, 4'b1000, 1'b1, 1'b1});
        // pointer wrapped to 0; backpressure for 5 cycles mid-packet
        tv.push_back('{4'b1001, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0});
        tv.push_back('{4'b0001, 4'b0000, 1'b1, 4'b0001, 4'b0001, 1'b1, 1'b0});
        for (int i = 0; i < 5; i++)
            tv.push_back('{4'b0001, 4'b0000, 1'b0, 4'b0001, 4'b0000, 1'b1, 1'b0});
        tv.push_back('{4'b0001, 4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b1, 1'b1});
        tv.push_back('{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0});
        tv.push_back('{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0});
        // granted requester drops valid, grant held
        tv.push_back('{4'b0100, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0});
        tv.push_back('{4'b0000, 4'b0000, 1'b1, 4'b0100, 4'b0100, 1'b0, 1'b0});
        tv.push_back('{4'b0000, 4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b0, 1'b0});
        tv.push_back('{4'b0100, 4'b0100, 1'b1, 4'b0100, 4'b0100, 1'b1, 1'b1});
        tv.push_back('{4'b0001, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0});
        tv.push_back('{4'b0001, 4'b0001, 1'b1, 4'b0001, 4'b0001, 1'b1, 1'b1});
        tv.push_back('{4'b0000, 4'b0000, 1'b1, 4'b0000, 4'b0000, 1'b0, 1'b0});

        repeat (3) @(posedge Clk);
        #1;
        check("rst_grant", {4'b0, PacketEnable_dw_o}, 8'h00);
        check("rst_ready", {4'b0, Ready_up_o}, 8'h00);
        check("rst_vdw", {7'b0, Valid_dw_o}, 8'h00);
        check("rst_err", {7'b0, PktLenErr_o}, 8'h00);
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        check("rel_grant", {4'b0, PacketEnable_dw_o}, 8'h01);

        for (int i = 0; i < tv.size(); i++) begin
            Valid_up_i = tv[i].valid;
            Tail_up_i  = tv[i].tail;
            Ready_dw_i = tv[i].ready;
            #1;
            check($sformatf("v%0d_grant", i), {4'b0, PacketEnable_dw_o}, {4'b0, tv[i].grant});
            check($sformatf("v%0d_rdy", i), {4'b0, Ready_up_o}, {4'b0, tv[i].rdy});
            check($sformatf("v%0d_vdw", i), {7'b0, Valid_dw_o}, {7'b0, tv[i].vdw});
            check($sformatf("v%0d_tdw", i), {7'b0, Tail_dw_o}, {7'b0, tv[i].tdw});
            check($sformatf("v%0d_err", i), {7'b0, PktLenErr_o}, 8'h00);
            @(posedge Clk); #1;
        end

        // length error: 16 flits legal, 17 flits flagged, sticky until clear
        send_pkt(2, 16, 1'b0);
        send_pkt(2, 17, 1'b0);
        @(posedge Clk); #1;
        check("err_sticky", {7'b0, PktLenErr_o}, 8'h01);
        PktLenErrClr_i = 1'b1;
        @(posedge Clk); #1;
        PktLenErrClr_i = 1'b0;
        check("err_cleared", {7'b0, PktLenErr_o}, 8'h00);
        send_pkt(2, 17, 1'b1);
        @(posedge Clk); #1;
        check("err_set_wins", {7'b0, PktLenErr_o}, 8'h01);

        // async reset during the second flit of a packet
        Valid_up_i = 4'b0100;
        Tail_up_i  = 4'b0000;
        Ready_dw_i = 1'b1;
        wait_grant(4'b0100);
        @(posedge Clk); #1;
        check("mid_grant", {4'b0, PacketEnable_dw_o}, 8'h04);
        #1;
        Rst_n = 1'b0;
        #1;
        check("arst_grant", {4'b0, PacketEnable_dw_o}, 8'h00);
        check("arst_vdw", {7'b0, Valid_dw_o}, 8'h00);
        check("arst_ready", {4'b0, Ready_up_o}, 8'h00);
        check("arst_err", {7'b0, PktLenErr_o}, 8'h00);
        Valid_up_i = 4'b1010;
        @(negedge Clk);
        Rst_n = 1'b1;
        @(posedge Clk); #1;
        check("arst_ptr0", {4'b0, PacketEnable_dw_o}, 8'h02);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
